// File: rtl/journey_pkg.sv
// Fare-calculation constants shared by the fare core and its registered wrapper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package journey_pkg;

    localparam logic [2:0] PATH_5PCT  = 3'b001;
    localparam logic [2:0] PATH_10PCT = 3'b010;
    localparam logic [2:0] PATH_0PCT  = 3'b100;

    localparam logic [1:0] JT_STD = 2'b00;
    localparam logic [1:0] JT_X19 = 2'b01;
    localparam logic [1:0] JT_X25 = 2'b10;

    localparam logic [7:0] BUCKET_LO = 8'd10;
    localparam logic [7:0] BUCKET_HI = 8'd35;

    localparam logic [3:0] PCT_5  = 4'd5;
    localparam logic [3:0] PCT_10 = 4'd10;

    localparam logic [14:0] MULT_19  = 15'd19;
    localparam logic [14:0] MULT_25  = 15'd25;
    localparam logic [14:0] MULT_DIV = 15'd10;

    localparam int RESULT_W = 16;

endpackage

// File: rtl/journey_fare_core.sv
// Combinational fare datapath: distance bucket, path surcharge, highway, journey multiplier, pax.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates whatever is on its inputs.
module journey_fare_core
    import journey_pkg::*;
(
    input  logic [2:0]  path,
    input  logic [1:0]  journey_type,
    input  logic [7:0]  distance,
    input  logic [7:0]  highway_distance,
    input  logic [7:0]  num_adults,
    input  logic [7:0]  num_children,
    output logic [19:0] product
);

    logic [9:0]  dist_x3;
    logic [8:0]  base;
    logic [3:0]  pct;
    logic [12:0] base_pct;
    logic [4:0]  extra;
    logic [9:0]  final_fare;
    logic [14:0] fare_scaled;
    logic [10:0] type_cost;
    logic [8:0]  pax;

    assign dist_x3 = {2'b00, distance} * 10'd3;

    always_comb begin
        base = {1'b0, distance};
        if (distance <= BUCKET_LO) begin
            base = {distance, 1'b0};
        end else if (distance <= BUCKET_HI) begin
            base = dist_x3[9:1];
        end
    end

    always_comb begin
        case (path)
            PATH_5PCT:  pct = PCT_5;
            PATH_10PCT: pct = PCT_10;
            PATH_0PCT:  pct = 4'd0;
            default:    pct = 4'd0;
        endcase
    end

    // Surcharge tops out at 25 (255 * 10 / 100), so 5 bits never truncate.
    assign base_pct   = {4'b0, base} * {9'b0, pct};
    assign extra      = 5'(base_pct / 13'd100);
    assign final_fare = {1'b0, base} + {5'b0, extra} + {2'b0, highway_distance};

    always_comb begin
        case (journey_type)
            JT_X19:  fare_scaled = {5'b0, final_fare} * MULT_19;
            JT_X25:  fare_scaled = {5'b0, final_fare} * MULT_25;
            default: fare_scaled = {5'b0, final_fare} * MULT_DIV;
        endcase
        type_cost = 11'(fare_scaled / MULT_DIV);
    end

    assign pax     = {1'b0, num_adults} + {1'b0, num_children};
    assign product = {9'b0, type_cost} * {11'b0, pax};

endmodule

// File: rtl/journey_selection.sv
// Registered ticket-fare calculator: one fare per clock, result wraps modulo 2^16.
// Latency: 1 cycle. Backpressure: none; a new result is captured every edge.
// Reset: rd clears the output register asynchronously, dropping any in-flight result.
module journey_selection
    import journey_pkg::*;
(
    input  logic                clk,
    input  logic                rd,
    input  logic [2:0]          path,
    input  logic [1:0]          journey_type,
    input  logic [7:0]          distance,
    input  logic [7:0]          highway_distance,
    input  logic [7:0]          num_adults,
    input  logic [7:0]          num_children,
    output logic [RESULT_W-1:0] total_cost
);

    logic [19:0]         product;
    logic [RESULT_W-1:0] total_cost_d;
    logic [RESULT_W-1:0] total_cost_q;

    journey_fare_core u_core (
        .path             (path),
        .journey_type     (journey_type),
        .distance         (distance),
        .highway_distance (highway_distance),
        .num_adults       (num_adults),
        .num_children     (num_children),
        .product          (product)
    );

    assign total_cost_d = RESULT_W'(product);

    always_ff @(posedge clk or negedge rd) begin
        if (!rd) begin
            total_cost_q <= '0;
        end else begin
            total_cost_q <= total_cost_d;
        end
    end

    assign total_cost = total_cost_q;

endmodule

// File: tb/tb_journey_selection.sv
// Bench for journey_selection: directed fare vectors, mid-stream reset, and randomized
// back-to-back vectors checked against an integer-arithmetic fare model.
module tb_journey_selection;

    logic        clk = 1'b0;
    logic        rd;
    logic [2:0]  path;
    logic [1:0]  journey_type;
    logic [7:0]  distance;
    logic [7:0]  highway_distance;
    logic [7:0]  num_adults;
    logic [7:0]  num_children;
    logic [15:0] total_cost;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int p, jt, d, hw, na, nc, exp;
    } vec_t;

    vec_t vt[12];

    always #5 clk = ~clk;

    journey_selection dut (
        .clk              (clk),
        .rd               (rd),
        .path             (path),
        .journey_type     (journey_type),
        .distance         (distance),
        .highway_distance (highway_distance),
        .num_adults       (num_adults),
        .num_children     (num_children),
        .total_cost       (total_cost)
    );

    function automatic int fare_model(int p, int jt, int d, int hw, int na, int nc);
        int base, pct, fin, tc;
        if (d <= 10)      base = d * 2;
        else if (d <= 35) base = (d * 3) / 2;
        else              base = d;
        if (p == 1)       pct = 5;
        else if (p == 2)  pct = 10;
        else              pct = 0;
        fin = base + (base * pct) / 100 + hw;
        if (jt == 1)      tc = (fin * 19) / 10;
        else if (jt == 2) tc = (fin * 25) / 10;
        else              tc = fin;
        return (tc * (na + nc)) % 65536;
    endfunction

    task automatic drive(int p, int jt, int d, int hw, int na, int nc);
        path             = 3'(p);
        journey_type     = 2'(jt);
        distance         = 8'(d);
        highway_distance = 8'(hw);
        num_adults       = 8'(na);
        num_children     = 8'(nc);
    endtask

    task automatic check(string tag, int exp);
        logic [15:0] e;
        e = 16'(exp);
        checks++;
        assert (total_cost === e)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, total_cost, e);
        end
    endtask

    initial begin
        int p, jt, d, hw, na, nc;

        vt[0]  = '{1, 0,   5,   0,   1,   0,   10};
        vt[1]  = '{1, 0,   5,   5,   1,   0,   15};
        vt[2]  = '{1, 1,   5,   0,   0,   1,   19};
        vt[3]  = '{2, 2,  20,   0,   2,   1,  246};
        vt[4]  = '{2, 2,  35,   5,   3,   2,  775};
        vt[5]  = '{4, 0,  36,   0,   1,   0,   36};
        vt[6]  = '{1, 1,  10,   0,   0,   0,    0};
        vt[7]  = '{0, 3,  40,   0,   1,   1,   80};
        vt[8]  = '{1, 1, 255, 255,   1,   1, 1982};
        vt[9]  = '{1, 0,   1,   0, 255, 255, 1020};
        vt[10] = '{2, 2, 255, 255, 100, 100, 5256};
        vt[11] = '{2, 2, 255, 255, 255,   0, 0};

        // Reset held with nonzero inputs, sampled before the first clock edge.
        rd = 1'b0;
        drive(2, 2, 255, 255, 100, 100);
        #2;
        check("reset_hold_no_edge", 0);

        @(negedge clk);
        check("reset_hold_after_edge", 0);
        drive(0, 0, 0, 0, 0, 0);
        rd = 1'b1;
        @(negedge clk);
        check("zero_inputs", 0);

        // Directed vectors, a new one every cycle.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].p, vt[i].jt, vt[i].d, vt[i].hw, vt[i].na, vt[i].nc);
            if (i == 11) vt[11].exp = fare_model(2, 2, 255, 255, 255, 0);
            @(negedge clk);
            check($sformatf("directed_%0d", i), vt[i].exp);
        end

        // Output must still show the previous result until the next edge.
        drive(1, 0, 5, 0, 1, 0);
        #2;
        check("hold_until_edge", vt[11].exp);
        @(negedge clk);
        check("after_edge", 10);

        // Mid-stream reset drops the in-flight result immediately.
        drive(2, 2, 20, 0, 2, 1);
        @(posedge clk);
        #1;
        check("pre_reset_value", 246);
        #2;
        rd = 1'b0;
        #1;
        check("reset_immediate", 0);
        drive(2, 2, 35, 5, 3, 2);
        @(negedge clk);
        check("reset_blocks_capture", 0);
        rd = 1'b1;
        @(negedge clk);
        check("first_after_release", 775);

        // Randomized back-to-back vectors, distance biased toward bucket edges.
        for (int i = 0; i < 300; i++) begin
            p  = int'($urandom_range(0, 7));
            jt = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       d = int'($urandom_range(8, 13));
                1:       d = int'($urandom_range(33, 38));
                default: d = int'($urandom_range(0, 255));
            endcase
            hw = int'($urandom_range(0, 255));
            na = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            nc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            drive(p, jt, d, hw, na, nc);
            @(negedge clk);
            check($sformatf("random_%0d", i), fare_model(p, jt, d, hw, na, nc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
